// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl -- instruction-fetch controller for the single-issue NPC core.
//
// Owns the architectural PC and walks one instruction at a time through
// fetch -> decode -> next-PC, so at most one instruction is in flight.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   imem_addr/valid/ready    fetch request (word-aligned address)
//   imem_rdata               instruction word, valid with imem_ready
//   inst/inst_pc/valid/ready captured instruction handed to decode
//   next_pc/pc_valid/ready   next PC from execute
//   halt                     stop fetching once the current instruction retires
//   pc                       architectural PC
//   fetch_cnt, stall_cnt     perf counters (zero unless IFU_PERF_CNT_EN)
//
// Build option: define IFU_PERF_CNT_EN to instantiate the fetch/stall counters.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_valid,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic [XLEN-1:0] next_pc,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAITPC = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t state, state_d;

  // Handshake qualifiers; only meaningful in their owning state.
  logic fetch_fire;
  logic pc_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= RESET_PC;
    end else begin
      state <= state_d;
      if (fetch_fire) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      if (pc_fire) pc <= next_pc;
    end
  end

  // Outputs are state decodes. The rst gate keeps every handshake quiet in
  // the reset cycle, whatever state the register still holds.
  always_comb begin
    state_d    = state;
    imem_valid = 1'b0;
    inst_valid = 1'b0;
    pc_ready   = 1'b0;
    fetch_fire = 1'b0;
    pc_fire    = 1'b0;
    unique case (state)
      S_REQ: begin
        imem_valid = !rst;
        fetch_fire = imem_ready;
        if (imem_ready) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        inst_valid = !rst;
        if (inst_ready) state_d = S_WAITPC;
      end
      S_WAITPC: begin
        pc_ready = !halt && !rst;
        // halt wins over a coincident next_pc: the PC stays on the last
        // delivered instruction.
        if (halt) begin
          state_d = S_HALT;
        end else if (pc_valid) begin
          pc_fire = 1'b1;
          state_d = S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_REQ;
    endcase
  end

  // Low two bits are dropped so memory only ever sees word addresses; pc
  // itself keeps whatever execute handed over.
  assign imem_addr = {pc[XLEN-1:2], 2'b00};

`ifdef IFU_PERF_CNT_EN
  logic [XLEN-1:0] fetch_q, stall_q;

  // Neither condition can be true in S_HALT, so the counters freeze there
  // without an explicit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (state == S_REQ && imem_ready)  fetch_q <= fetch_q + 1'b1;
      if (state == S_REQ && !imem_ready) stall_q <= stall_q + 1'b1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
